modexp_seq: RTL and testbench

MODEXP_SEQ -- requirements
Module: modexp_seq

---
 rtl/modexp_seq_if.sv | 29 ++
 rtl/modexp_seq.sv | 158 +++++++++++++++
 tb/tb_modexp_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_seq_if.sv
// Control bundle between the square-and-multiply sequencer and its requester/datapath.
// The requester drives start/exp; the modular multiplier drives mult_done.
interface modexp_seq_if #(
    parameter int EXP_WIDTH = 8
);
    logic                 start;
    logic [EXP_WIDTH-1:0] exp;
    logic                 mult_done;
    logic [1:0]           sel_a;
    logic [1:0]           sel_b;
    logic                 mult_start;
    logic                 res_we;
    logic                 res_src;
    logic                 busy;
    logic                 done;

    // Handshake: start is taken only while busy=0 (exp latched in that same cycle);
    // mult_start, mult_done and done are single-cycle pulses, and selects stay frozen
    // from mult_start through the cycle mult_done is accepted.
    modport master (
        output start, exp, mult_done,
        input  sel_a, sel_b, mult_start, res_we, res_src, busy, done
    );

    modport slave (
        input  start, exp, mult_done,
        output sel_a, sel_b, mult_start, res_we, res_src, busy, done
    );
endinterface

// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply sequencer: steers operand muxes and the result
// register around an external modular multiplier with arbitrary (>=1 cycle) latency.
module modexp_seq #(
    parameter int EXP_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    modexp_seq_if.slave bus,
    output logic [2:0]  o_dbg_state
);
    localparam int IDX_W = $clog2(EXP_WIDTH);

    localparam logic [1:0] SEL_ONE  = 2'b00;
    localparam logic [1:0] SEL_R    = 2'b01;
    localparam logic [1:0] SEL_M    = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_SQUARE   = 3'd2,
        S_WAIT_SQ  = 3'd3,
        S_MULT     = 3'd4,
        S_WAIT_MUL = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [IDX_W-1:0]     r_idx;

    logic       w_load;
    logic       w_dec;
    logic       w_bit;
    logic       w_last;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    logic       w_mult_start;
    logic       w_res_we;
    logic       w_res_src;
    logic       w_busy;
    logic       w_done;

    assign w_bit  = r_exp[r_idx];
    assign w_last = (r_idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_exp <= bus.exp;
                r_idx <= IDX_W'(EXP_WIDTH - 1);
            end else if (w_dec) begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    // The result write in the wait states qualifies the multiplier's done pulse in the
    // same cycle, so each multiply costs exactly latency+1 cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_sel_a      = SEL_ZERO;
        w_sel_b      = SEL_ZERO;
        w_mult_start = 1'b0;
        w_res_we     = 1'b0;
        w_res_src    = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                w_sel_a     = SEL_ONE;
                w_res_we    = 1'b1;
                w_state_nxt = S_SQUARE;
            end
            S_SQUARE: begin
                w_sel_a      = SEL_R;
                w_sel_b      = SEL_R;
                w_mult_start = 1'b1;
                w_state_nxt  = S_WAIT_SQ;
            end
            S_WAIT_SQ: begin
                w_sel_a = SEL_R;
                w_sel_b = SEL_R;
                if (bus.mult_done) begin
                    w_res_src = 1'b1;
                    w_res_we  = 1'b1;
                    if (w_bit) begin
                        w_state_nxt = S_MULT;
                    end else if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_dec       = 1'b1;
                        w_state_nxt = S_SQUARE;
                    end
                end
            end
            S_MULT: begin
                w_sel_a      = SEL_R;
                w_sel_b      = SEL_M;
                w_mult_start = 1'b1;
                w_state_nxt  = S_WAIT_MUL;
            end
            S_WAIT_MUL: begin
                w_sel_a = SEL_R;
                w_sel_b = SEL_M;
                if (bus.mult_done) begin
                    w_res_src = 1'b1;
                    w_res_we  = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_dec       = 1'b1;
                        w_state_nxt = S_SQUARE;
                    end
                end
            end
            S_DONE: begin
                w_busy      = 1'b0;
                w_done      = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // An abort must not leak a final multiplier kick or result write in the reset cycle.
    assign bus.mult_start = w_mult_start & ~rst;
    assign bus.res_we     = w_res_we & ~rst;
    assign bus.res_src    = w_res_src;
    assign bus.sel_a      = w_sel_a;
    assign bus.sel_b      = w_sel_b;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign o_dbg_state    = r_state;

    a_start_no_write: assert property (@(posedge clk) disable iff (rst)
        bus.mult_start |-> !bus.res_we);
    a_done_to_idle: assert property (@(posedge clk) disable iff (rst)
        bus.done |=> !bus.busy);
endmodule

// File: tb/tb_modexp_seq.sv
// Directed bench for modexp_seq: a 4-bit and an 8-bit instance, each driven by a
// latency-programmable modular multiplier and result-register model.
`timescale 1ns/1ps
module tb_modexp_seq;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    modexp_seq_if #(.EXP_WIDTH(4)) bus4 ();
    modexp_seq_if #(.EXP_WIDTH(8)) bus8 ();
    logic [2:0] dbg4;
    logic [2:0] dbg8;

    modexp_seq #(.EXP_WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4), .o_dbg_state(dbg4));
    modexp_seq #(.EXP_WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8), .o_dbg_state(dbg8));

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_sel_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mux(input logic [1:0] s, input logic [31:0] r, input logic [31:0] m);
        case (s)
            2'b00:   return 32'd1;
            2'b01:   return r;
            2'b10:   return m;
            default: return 32'd0;
        endcase
    endfunction

    // Multiplier + R register model, 4-bit instance
    int          lat4 = 1, cnt4 = 0, t04 = 0, busy_cnt4 = 0, busy_first4 = -1, busy_last4 = -1;
    logic [31:0] m4, mod4, r4, pa4, pb4;
    logic        md4 = 1'b0, spur4 = 1'b0;
    int          ms_cyc4[$], done_cyc4[$], we_cyc4[$];
    logic [1:0]  ms_selb4[$];
    assign bus4.mult_done = md4 | spur4;

    always begin
        @(negedge clk);
        md4 = 1'b0;
        if (cnt4 > 0) begin
            cnt4--;
            if (cnt4 == 0) md4 = 1'b1;
        end
        #1;
        if (bus4.mult_start) begin
            cnt4 = lat4;
            pa4  = mux(bus4.sel_a, r4, m4);
            pb4  = mux(bus4.sel_b, r4, m4);
            ms_cyc4.push_back(cyc - t04);
            ms_selb4.push_back(bus4.sel_b);
        end
        if (bus4.res_we) begin
            r4 = bus4.res_src ? (pa4 * pb4) % mod4 : mux(bus4.sel_a, r4, m4);
            we_cyc4.push_back(cyc - t04);
        end
        if (bus4.done) done_cyc4.push_back(cyc - t04);
        if (bus4.busy) begin
            busy_cnt4++;
            if (busy_first4 < 0) busy_first4 = cyc - t04;
            busy_last4 = cyc - t04;
        end
    end

    // Same model for the 8-bit instance, optionally with a random latency per multiply
    int          lat8 = 1, cnt8 = 0, t08 = 0, lat_sum8 = 0;
    logic        rand8 = 1'b0;
    logic [31:0] m8, mod8, r8, pa8, pb8;
    logic        md8 = 1'b0;
    int          ms_cyc8[$], done_cyc8[$];
    logic [1:0]  ms_selb8[$];
    assign bus8.mult_done = md8;

    always begin
        @(negedge clk);
        md8 = 1'b0;
        if (cnt8 > 0) begin
            cnt8--;
            if (cnt8 == 0) md8 = 1'b1;
        end
        #1;
        if (bus8.mult_start) begin
            cnt8 = rand8 ? int'($urandom_range(1, 5)) : lat8;
            lat_sum8 += cnt8 + 1;
            pa8  = mux(bus8.sel_a, r8, m8);
            pb8  = mux(bus8.sel_b, r8, m8);
            ms_cyc8.push_back(cyc - t08);
            ms_selb8.push_back(bus8.sel_b);
        end
        if (bus8.res_we) r8 = bus8.res_src ? (pa8 * pb8) % mod8 : mux(bus8.sel_a, r8, m8);
        if (bus8.done) done_cyc8.push_back(cyc - t08);
    end

    task automatic clr4();
        ms_cyc4.delete(); ms_selb4.delete(); done_cyc4.delete(); we_cyc4.delete();
        busy_cnt4 = 0; busy_first4 = -1; busy_last4 = -1;
    endtask

    task automatic clr8();
        ms_cyc8.delete(); ms_selb8.delete(); done_cyc8.delete(); lat_sum8 = 0;
    endtask

    task automatic at4(input int k);
        while (cyc - t04 < k) @(negedge clk);
    endtask

    task automatic start4(input logic [3:0] e);
        @(negedge clk);
        bus4.exp = e; bus4.start = 1'b1; t04 = cyc;
        @(negedge clk);
        bus4.start = 1'b0; bus4.exp = ~e;
    endtask

    task automatic start8(input logic [7:0] e);
        @(negedge clk);
        bus8.exp = e; bus8.start = 1'b1; t08 = cyc;
        @(negedge clk);
        bus8.start = 1'b0; bus8.exp = ~e;
    endtask

    task automatic wait_done4(input int budget);
        int k = 0;
        while (done_cyc4.size() < 1 && k < budget) begin @(negedge clk); #2; k++; end
        check("done4_timeout", 32'(done_cyc4.size() >= 1), 1);
    endtask

    task automatic wait_done8(input int budget);
        int k = 0;
        while (done_cyc8.size() < 1 && k < budget) begin @(negedge clk); #2; k++; end
        check("done8_timeout", 32'(done_cyc8.size() >= 1), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus4.start = 1'b0; bus4.exp = '0; bus8.start = 1'b0; bus8.exp = '0;
        m4 = 2; mod4 = 1000; r4 = 0; m8 = 3; mod8 = 101; r8 = 0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", bus4.busy, 0);
        check("rst_done", bus4.done, 0);
        check("rst_sel_a", bus4.sel_a, 2'b11);
        check("rst_sel_b", bus4.sel_b, 2'b11);
        check("rst_mstart", bus4.mult_start, 0);
        check("rst_we", bus4.res_we, 0);
        check("rst_src", bus4.res_src, 0);
        check("rst_state", dbg4, 0);
        check("rst8_busy", bus8.busy, 0);
        check("rst8_sel_b", bus8.sel_b, 2'b11);
        @(negedge clk); rst = 1'b0;

        // spurious mult_done while idle
        @(negedge clk); spur4 = 1'b1; #2;
        check("idle_spur_we", bus4.res_we, 0);
        @(negedge clk); spur4 = 1'b0; #2;
        check("idle_spur_state", dbg4, 0);
        check("idle_spur_busy", bus4.busy, 0);

        // reset wins over start
        @(negedge clk); rst = 1'b1; bus4.start = 1'b1; bus4.exp = 4'hF;
        @(negedge clk); rst = 1'b0; bus4.start = 1'b0; #2;
        check("rst_prio_busy", bus4.busy, 0);
        check("rst_prio_state", dbg4, 0);

        // exp=1011, L=3: 2^11 mod 1000 = 48
        clr4(); m4 = 2; mod4 = 1000; lat4 = 3;
        start4(4'b1011);
        wait_done4(60);
        repeat (3) @(negedge clk); #2;
        check("t33_done_cyc", done_cyc4[0], 30);
        check("t33_done_cnt", done_cyc4.size(), 1);
        check("t33_busy_first", busy_first4, 1);
        check("t33_busy_last", busy_last4, 30);
        check("t33_busy_cnt", busy_cnt4, 30);
        check("t33_ms_cnt", ms_cyc4.size(), 7);
        check("t33_init_we", we_cyc4.size() > 0 ? we_cyc4[0] : -1, 1);
        check("t33_we_cnt", we_cyc4.size(), 8);
        check("t33_r", r4, 48);
        exp_q = {32'd2, 32'd6, 32'd10, 32'd14, 32'd18, 32'd22, 32'd26};
        exp_sel_q = {32'd1, 32'd2, 32'd1, 32'd1, 32'd2, 32'd1, 32'd2};
        n = 0;
        while (exp_q.size() > 0) begin
            check("t33_ms_cyc", n < ms_cyc4.size() ? ms_cyc4[n] : -1, exp_q.pop_front());
            check("t33_ms_selb", n < ms_selb4.size() ? 32'(ms_selb4[n]) : 32'hFFFF_FFFF,
                  exp_sel_q.pop_front());
            n++;
        end

        // exp=0, L=1: squarings only, R back to 1
        clr4(); r4 = 7; lat4 = 1;
        start4(4'b0000);
        wait_done4(40);
        #2;
        check("t34_done_cyc", done_cyc4[0], 10);
        check("t34_ms_cnt", ms_cyc4.size(), 4);
        n = 0;
        foreach (ms_selb4[i]) if (ms_selb4[i] == 2'b10) n++;
        check("t34_no_mult", n, 0);
        check("t34_r", r4, 1);

        // ignored starts (WAIT_SQ, DONE) and spurious done in SQUARE; restart right after DONE
        clr4(); m4 = 3; lat4 = 2;
        @(negedge clk); bus4.exp = 4'b0101; bus4.start = 1'b1; t04 = cyc;
        at4(1); bus4.start = 1'b0;
        at4(2); spur4 = 1'b1;
        at4(3); spur4 = 1'b0; bus4.start = 1'b1;
        at4(4); bus4.start = 1'b0;
        at4(20); bus4.start = 1'b1;
        at4(22); bus4.start = 1'b0; bus4.exp = 4'b0000;
        at4(50); #2;
        check("t36_done_cnt", done_cyc4.size(), 2);
        check("t36_done0", done_cyc4.size() > 0 ? done_cyc4[0] : -1, 20);
        check("t36_done1", done_cyc4.size() > 1 ? done_cyc4[1] : -1, 41);
        check("t36_ms_cnt", ms_cyc4.size(), 12);
        check("t36_r", r4, 243);

        // reset during WAIT_MUL, multiplier answers one cycle later
        clr4(); m4 = 2; lat4 = 3;
        start4(4'b1111);
        at4(8); rst = 1'b1; #2;
        check("t37_in_wait_mul", bus4.sel_b, 2'b10);
        check("t37_rst_no_we", bus4.res_we, 0);
        at4(9); rst = 1'b0; #2;
        check("t37_md_seen", bus4.mult_done, 1);
        check("t37_busy", bus4.busy, 0);
        check("t37_state", dbg4, 0);
        check("t37_sel_a", bus4.sel_a, 2'b11);
        check("t37_sel_b", bus4.sel_b, 2'b11);
        check("t37_we", bus4.res_we, 0);
        check("t37_mstart", bus4.mult_start, 0);
        at4(14); #2;
        check("t37_ms_cnt", ms_cyc4.size(), 2);
        check("t37_we_cnt", we_cyc4.size(), 2);
        check("t37_no_done", done_cyc4.size(), 0);
        clr4(); r4 = 0; lat4 = 1;
        start4(4'b0011);
        wait_done4(40);
        check("t37_re_done_cyc", done_cyc4[0], 14);
        check("t37_re_r", r4, 8);

        // 8-bit: 3^255 mod 101 = 60 with random multiplier latency
        clr8(); r8 = 0; rand8 = 1'b1;
        start8(8'hFF);
        wait_done8(400);
        #2;
        check("t35_r", r8, 60);
        check("t35_ms_cnt", ms_cyc8.size(), 16);
        check("t35_latency", done_cyc8[0], 2 + lat_sum8);

        // 8-bit: 3^128 mod 101 = 68 with L=2
        clr8(); r8 = 5; rand8 = 1'b0; lat8 = 2;
        start8(8'h80);
        wait_done8(200);
        #2;
        check("t8_done_cyc", done_cyc8[0], 29);
        check("t8_r", r8, 68);
        check("t8_ms_cnt", ms_cyc8.size(), 9);
        n = 0;
        foreach (ms_selb8[i]) if (ms_selb8[i] == 2'b10) n++;
        check("t8_mult_cnt", n, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
